// File: rtl/vga_pkg.sv
// Shared types for the VGA mode sequencer: FSM states and display mode encoding.
package vga_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_OLD = 2'd1,
    RST_NEW  = 2'd2,
    SETTLE   = 2'd3
  } seq_state_t;

  typedef enum logic {
    MODE_640 = 1'b0,
    MODE_800 = 1'b1
  } mode_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus debounce counter for the raw board mode switch.
// The debounced level only follows the synced input after DEBOUNCE_CYCLES stable cycles.
module sw_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_db
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 16'd1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  // Any cycle where the synced level agrees with sw_db restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q >= CntLast) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/vga_mode_sequencer.sv
// Glitch-free switching between the 640x480 and 800x600 VGA controllers.
// Optional macro VGA_MODE_TIMEOUT_EN adds TIMEOUT_CYCLES and a sticky timeout_flag output.
module vga_mode_sequencer
  import vga_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  RST_CYCLES      = 8'd4,
  parameter logic [3:0]  SETTLE_FRAMES   = 4'd2
`ifdef VGA_MODE_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd2000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  input  logic fs_640,
  input  logic fs_800,
  output logic sel,
  output logic blank,
  output logic rst_n_640,
  output logic rst_n_800,
  output logic en_640,
  output logic en_800,
  output logic busy
`ifdef VGA_MODE_TIMEOUT_EN
  ,
  output logic timeout_flag
`endif
);

  localparam int unsigned RCW = $clog2(RST_CYCLES) + 1;
  localparam int unsigned SCW = $clog2(SETTLE_FRAMES) + 1;
  localparam logic [RCW-1:0] RstLast = RCW'(RST_CYCLES - 8'd1);
  localparam logic [SCW-1:0] SetLast = SCW'(SETTLE_FRAMES - 4'd1);

  logic sw_db;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .sw_db(sw_db)
  );

  seq_state_t     state_q, state_d;
  mode_t          target_q, target_d;
  mode_t          sel_q, sel_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0] set_cnt_q, set_cnt_d;
  logic           blank_q, blank_d;
  logic           busy_q, busy_d;
  logic           rst_n_640_q, rst_n_640_d;
  logic           rst_n_800_q, rst_n_800_d;
  logic           en_640_q, en_640_d;
  logic           en_800_q, en_800_d;
  logic           fs_sel;
  logic           fs_go;

  // Frame starts from the unselected controller never reach the FSM.
  assign fs_sel = (sel_q == MODE_800) ? fs_800 : fs_640;

`ifdef VGA_MODE_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TCW-1:0] TmoLast = TCW'(TIMEOUT_CYCLES - 32'd1);

  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           tmo_fire;
  logic           waiting;
  logic           timeout_q, timeout_d;

  assign waiting  = (state_q == WAIT_OLD) || (state_q == SETTLE);
  assign tmo_fire = waiting && (tmo_cnt_q >= TmoLast);
  assign fs_go    = fs_sel || tmo_fire;

  always_comb begin
    tmo_cnt_d = '0;
    if (waiting && !fs_sel && !tmo_fire) begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end
    timeout_d = timeout_q;
    // An abort in WAIT_OLD takes priority, so that timeout is not acted upon.
    if (tmo_fire && !fs_sel && !((state_q == WAIT_OLD) && (sw_db == sel_q))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign fs_go = fs_sel;
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sel_d     = sel_q;
    rst_cnt_d = '0;
    set_cnt_d = '0;
    unique case (state_q)
      RUN: begin
        if (sw_db != sel_q) begin
          target_d = mode_t'(sw_db);
          state_d  = WAIT_OLD;
        end
      end
      WAIT_OLD: begin
        if (sw_db == sel_q) begin
          state_d = RUN;
        end else if (fs_go) begin
          state_d = RST_NEW;
          sel_d   = target_q;
        end
      end
      RST_NEW: begin
        if (rst_cnt_q >= RstLast) begin
          state_d = SETTLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      SETTLE: begin
        set_cnt_d = set_cnt_q;
        if (fs_go) begin
          if (set_cnt_q >= SetLast) begin
            state_d = RUN;
          end else begin
            set_cnt_d = set_cnt_q + SCW'(1);
          end
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on clock edges.
  always_comb begin
    blank_d     = (state_d == RST_NEW) || (state_d == SETTLE);
    busy_d      = (state_d != RUN);
    en_640_d    = (sel_d == MODE_640);
    en_800_d    = (sel_d == MODE_800);
    rst_n_640_d = (sel_d == MODE_640) && (state_d != RST_NEW);
    rst_n_800_d = (sel_d == MODE_800) && (state_d != RST_NEW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RST_NEW;
      target_q    <= MODE_640;
      sel_q       <= MODE_640;
      rst_cnt_q   <= '0;
      set_cnt_q   <= '0;
      blank_q     <= 1'b1;
      busy_q      <= 1'b1;
      rst_n_640_q <= 1'b0;
      rst_n_800_q <= 1'b0;
      en_640_q    <= 1'b1;
      en_800_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      sel_q       <= sel_d;
      rst_cnt_q   <= rst_cnt_d;
      set_cnt_q   <= set_cnt_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      rst_n_640_q <= rst_n_640_d;
      rst_n_800_q <= rst_n_800_d;
      en_640_q    <= en_640_d;
      en_800_q    <= en_800_d;
    end
  end

  assign sel       = sel_q;
  assign blank     = blank_q;
  assign busy      = busy_q;
  assign rst_n_640 = rst_n_640_q;
  assign rst_n_800 = rst_n_800_q;
  assign en_640    = en_640_q;
  assign en_800    = en_800_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer: expected output vectors are queued per step and drained
// cycle by cycle against the DUT.
module tb_vga_mode_sequencer;

  localparam int ST_RUN  = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_RST  = 2;
  localparam int ST_SET  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic fs_640 = 1'b0;
  logic fs_800 = 1'b0;
  logic sel, blank, rst_n_640, rst_n_800, en_640, en_800, busy;
`ifdef VGA_MODE_TIMEOUT_EN
  logic timeout_flag;
`endif

  always #5 clk = ~clk;

  vga_mode_sequencer #(
    .DEBOUNCE_CYCLES(16'd8),
    .RST_CYCLES     (8'd4),
    .SETTLE_FRAMES  (4'd2)
`ifdef VGA_MODE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (32'd100)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .fs_640   (fs_640),
    .fs_800   (fs_800),
    .sel      (sel),
    .blank    (blank),
    .rst_n_640(rst_n_640),
    .rst_n_800(rst_n_800),
    .en_640   (en_640),
    .en_800   (en_800),
    .busy     (busy)
`ifdef VGA_MODE_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [6:0] obs;
  assign obs = {sel, blank, rst_n_640, rst_n_800, en_640, en_800, busy};

  // Output vector {sel, blank, rst_n_640, rst_n_800, en_640, en_800, busy} for a state/mode.
  function automatic logic [6:0] model(input int st, input logic s);
    logic b, bz, r640, r800;
    b    = (st == ST_RST) || (st == ST_SET);
    bz   = (st != ST_RUN);
    r640 = !s && (st != ST_RST);
    r800 = s && (st != ST_RST);
    return {s, b, r640, r800, !s, s, bz};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input int st, input logic s, input int n = 1);
    exp_t e;
    e.tag = tag;
    e.exp = model(st, s);
    repeat (n) sb_q.push_back(e);
  endtask

  // Compare the queue head now, then advance one cycle per remaining entry.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
      if (sb_q.size() > 0) tick();
    end
  endtask

  task automatic pulse(input logic which);
    if (which) fs_800 = 1'b1;
    else fs_640 = 1'b1;
    tick();
    fs_640 = 1'b0;
    fs_800 = 1'b0;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    push_exp("reset", ST_RST, 1'b0);
    drain();

    // Power-up sequence into 640x480.
    rst_n = 1'b1;
    push_exp("rst640_low", ST_RST, 1'b0, 4);
    push_exp("settle640", ST_SET, 1'b0);
    drain();
    pulse(1'b1);
    push_exp("settle_ign800", ST_SET, 1'b0);
    drain();
    pulse(1'b0);
    push_exp("settle_fs1", ST_SET, 1'b0);
    drain();
    pulse(1'b0);
    push_exp("init_run", ST_RUN, 1'b0);
    drain();

    // Short glitch must not be accepted.
    sw = 1'b1;
    tick(5);
    sw = 1'b0;
    push_exp("glitch_run", ST_RUN, 1'b0, 20);
    drain();

    // Full switch to 800x600.
    sw = 1'b1;
    push_exp("db_wait", ST_RUN, 1'b0, 11);
    push_exp("wait_old", ST_WAIT, 1'b0);
    drain();
    pulse(1'b1);
    push_exp("wait_ign800", ST_WAIT, 1'b0);
    drain();
    pulse(1'b0);
    push_exp("rst800_low", ST_RST, 1'b1, 4);
    push_exp("settle800", ST_SET, 1'b1);
    drain();
    pulse(1'b0);
    push_exp("settle_ign640", ST_SET, 1'b1);
    drain();
    pulse(1'b1);
    push_exp("settle800_fs1", ST_SET, 1'b1);
    drain();
    pulse(1'b1);
    push_exp("run800", ST_RUN, 1'b1);
    drain();

    // Request then withdraw before a frame start; abort beats a coincident fs_800.
    sw = 1'b0;
    push_exp("abort_db", ST_RUN, 1'b1, 11);
    push_exp("abort_wait_old", ST_WAIT, 1'b1);
    drain();
    sw = 1'b1;
    push_exp("abort_wait", ST_WAIT, 1'b1, 11);
    drain();
    fs_800 = 1'b1;
    tick();
    fs_800 = 1'b0;
    push_exp("abort_wins", ST_RUN, 1'b1, 6);
    drain();

    // Switch to 640 with the switch reverting during SETTLE.
    sw = 1'b0;
    push_exp("back_db", ST_RUN, 1'b1, 11);
    push_exp("back_wait", ST_WAIT, 1'b1);
    drain();
    pulse(1'b1);
    push_exp("back_rst", ST_RST, 1'b0, 4);
    push_exp("back_settle", ST_SET, 1'b0);
    drain();
    sw = 1'b1;
    push_exp("settle_ign_sw", ST_SET, 1'b0, 12);
    drain();
    pulse(1'b0);
    push_exp("back_fs1", ST_SET, 1'b0);
    drain();
    pulse(1'b0);
    push_exp("toggle_run", ST_RUN, 1'b0);
    push_exp("toggle_rewait", ST_WAIT, 1'b0);
    drain();
    pulse(1'b0);
    push_exp("reswitch_rst", ST_RST, 1'b1, 2);
    drain();

    // Reset mid-sequence discards everything.
    rst_n = 1'b0;
    sw = 1'b0;
    tick();
    push_exp("midreset", ST_RST, 1'b0);
    drain();
    rst_n = 1'b1;
    push_exp("post_rst", ST_RST, 1'b0, 4);
    push_exp("post_settle", ST_SET, 1'b0);
    drain();
    pulse(1'b0);
    pulse(1'b0);
    push_exp("post_run", ST_RUN, 1'b0, 3);
    drain();

`ifdef VGA_MODE_TIMEOUT_EN
    check_bit("tmo_flag_clear", timeout_flag, 1'b0);
    sw = 1'b1;
    push_exp("tmo_db", ST_RUN, 1'b0, 11);
    push_exp("tmo_wait", ST_WAIT, 1'b0, 100);
    push_exp("tmo_rst", ST_RST, 1'b1);
    drain();
    check_bit("tmo_flag_set", timeout_flag, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
